// File: rtl/uart_tx_fifo_if.sv
// Purpose: producer-side write port and transmitter-side launch port of the UART TX byte buffer.
// Latency: wires only; all timing lives in uart_tx_fifo.
// Backpressure: none on the wire; the producer watches full/count, and dropped writes pulse overflow.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  // Producer side
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  // Transmitter side
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_done_tick;

  // Environment view: drives writes and the done tick, observes everything else
  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, count, overflow, tx_start, tx_data
  );

  // Buffer view: the uart_tx_fifo block itself
  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, count, overflow, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: circular byte FIFO feeding a UART transmitter, one tx_start pulse per byte, next launch after tx_done_tick.
// Latency: byte stored at edge N launches (tx_start high) after edge N+1; next frame launches 1 cycle after tx_done_tick.
// Backpressure: none to the producer; a write while full is dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_tx_fifo_if.slave   bus
);

  localparam int                 DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  state_t                state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  overflow_q, overflow_d;

  logic full, empty, push, pop;

  // Status decoded from the registered count only, so a fresh byte cannot be popped in the cycle it is written
  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    push  = bus.wr_en && !full;
    pop   = (state_q == IDLE) && !empty;
  end

  // Next-state logic for pointers, occupancy, overflow flag and the launch sequencer
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    overflow_d = bus.wr_en && full;

    if (push) begin
      wp_d = wp_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = mem_q[rp_q];
          rp_d       = rp_q + 1'b1;
          tx_start_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done_tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage array is intentionally left out of reset; only accepted writes touch it
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= bus.wr_data;
    end
  end

  // Control state and registered outputs; reset drops everything queued and in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Purpose: self-checking bench for uart_tx_fifo: vector table plus multi-cycle sequences.
// Latency: inputs change on the falling edge, outputs are compared on the following falling edge.
// Backpressure: a small transmitter model returns tx_done_tick a programmable number of cycles after tx_start.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic man_done   = 1'b0;
  logic model_done = 1'b0;
  assign bus.tx_done_tick = man_done | model_done;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Transmitter model: captures launched bytes, answers with a done tick after dly cycles
  bit         model_en = 1'b0;
  int         dly      = 5;
  int         busy     = 0;
  int         dbl      = 0;
  logic       prev_st  = 1'b0;
  logic [7:0] launched [$];

  always @(negedge clk) begin
    model_done = 1'b0;
    if (bus.tx_start === 1'b1 && prev_st === 1'b1) dbl++;
    prev_st = bus.tx_start;
    if (model_en) begin
      if (bus.tx_start === 1'b1) begin
        launched.push_back(bus.tx_data);
        busy = dly;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) model_done = 1'b1;
      end
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       done;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       st;
    logic       ovf;
    logic [7:0] txd;
  } vec_t;

  vec_t vt [20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    logic       full_seen;
    logic [4:0] exp_cnt;

    // Inputs per cycle and the outputs expected after the following rising edge
    vt[0]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vt[3]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[4]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[6]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vt[7]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[10] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[11] = '{1'b1, 8'h77, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
    vt[12] = '{1'b1, 8'h88, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77};
    vt[13] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};
    vt[14] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};
    vt[15] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};
    vt[16] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h88};
    vt[17] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h88};
    vt[18] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h88};
    vt[19] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h88};

    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    reset_n     = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state, then 20 idle cycles
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_start", 32'(bus.tx_start), 32'd0);
      chk("idle_count", 32'(bus.count), 32'd0);
      chk("idle_empty", 32'(bus.empty), 32'd1);
      chk("idle_data", 32'(bus.tx_data), 32'd0);
    end

    // Table-driven vectors
    for (int i = 0; i < 20; i++) begin
      bus.wr_en   = vt[i].wr;
      bus.wr_data = vt[i].wd;
      man_done    = vt[i].done;
      step();
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vt[i].emp));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vt[i].ful));
      chk($sformatf("v%0d_start", i), 32'(bus.tx_start), 32'(vt[i].st));
      chk($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_data", i), 32'(bus.tx_data), 32'(vt[i].txd));
    end
    bus.wr_en = 1'b0;
    man_done  = 1'b0;

    // Single byte with a 50-cycle frame
    launched.delete();
    dly      = 50;
    model_en = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    chk("a5_count1", 32'(bus.count), 32'd1);
    chk("a5_nostart", 32'(bus.tx_start), 32'd0);
    step();
    chk("a5_start", 32'(bus.tx_start), 32'd1);
    chk("a5_count0", 32'(bus.count), 32'd0);
    chk("a5_data", 32'(bus.tx_data), 32'hA5);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("a5_hold_data", 32'(bus.tx_data), 32'hA5);
      chk("a5_one_start", 32'(bus.tx_start), 32'd0);
    end
    chk("a5_launches", 32'(launched.size()), 32'd1);

    // 16-byte burst against a busy transmitter
    launched.delete();
    dly       = 5;
    full_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(i);
      step();
      chk("burst_full", 32'(bus.full), 32'd0);
    end
    bus.wr_en = 1'b0;
    t = 0;
    while (launched.size() < 16 && t < 400) begin
      step();
      full_seen = full_seen | bus.full;
      t++;
    end
    repeat (12) step();
    chk("burst_launches", 32'(launched.size()), 32'd16);
    chk("burst_full_seen", 32'(full_seen), 32'd0);
    for (int k = 0; k < launched.size(); k++) begin
      chk($sformatf("burst_order%0d", k), 32'(launched[k]), 32'(k));
    end
    chk("burst_double_start", 32'(dbl), 32'd0);
    model_en = 1'b0;

    // Overflow: transmitter stalls, 18 writes
    for (int i = 0; i < 18; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h40 + i);
      step();
      exp_cnt = (i == 0) ? 5'd1 : ((i > 16) ? 5'd16 : 5'(i));
      chk($sformatf("ovf_count%0d", i), 32'(bus.count), 32'(exp_cnt));
      chk($sformatf("ovf_full%0d", i), 32'(bus.full), 32'(exp_cnt == 5'd16));
      chk($sformatf("ovf_flag%0d", i), 32'(bus.overflow), 32'(i == 17));
    end
    bus.wr_en = 1'b0;
    step();
    chk("ovf_pulse_end", 32'(bus.overflow), 32'd0);
    chk("ovf_inflight", 32'(bus.tx_data), 32'h40);
    chk("ovf_count_hold", 32'(bus.count), 32'd16);

    // Drain: 0x41..0x50 must follow, 0x51 was dropped
    launched.delete();
    dly      = 3;
    model_en = 1'b1;
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    t = 0;
    while (launched.size() < 16 && t < 400) begin
      step();
      t++;
    end
    repeat (10) step();
    chk("drain_launches", 32'(launched.size()), 32'd16);
    for (int k = 0; k < launched.size(); k++) begin
      chk($sformatf("drain_order%0d", k), 32'(launched[k]), 32'(8'h41 + k));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    model_en = 1'b0;

    // Reset while waiting on a frame with 5 bytes queued
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h60 + i);
      step();
    end
    bus.wr_en = 1'b0;
    step();
    chk("rq_count", 32'(bus.count), 32'd5);
    chk("rq_data", 32'(bus.tx_data), 32'h60);
    reset_n = 1'b0;
    #1;
    chk("rq_rst_count", 32'(bus.count), 32'd0);
    chk("rq_rst_empty", 32'(bus.empty), 32'd1);
    chk("rq_rst_full", 32'(bus.full), 32'd0);
    chk("rq_rst_start", 32'(bus.tx_start), 32'd0);
    chk("rq_rst_data", 32'(bus.tx_data), 32'd0);
    chk("rq_rst_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rq_post_start", 32'(bus.tx_start), 32'd0);
      chk("rq_post_empty", 32'(bus.empty), 32'd1);
    end
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h99;
    step();
    bus.wr_en = 1'b0;
    chk("rq_new_count", 32'(bus.count), 32'd1);
    step();
    chk("rq_new_start", 32'(bus.tx_start), 32'd1);
    chk("rq_new_data", 32'(bus.tx_data), 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
